// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register: occupancy states and
// the MEM/WB payload widths used when instantiating the stage at top level.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } cnt_st_e;

   localparam int MEMWB_CTRL_W = 2;
   localparam int MEMWB_DATA_W = 64;
   localparam int MEMWB_TAG_W  = 5;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload stream between two pipeline stages; the producer
// side uses the master modport, the consumer side the slave modport.
interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int CTRL_W = MEMWB_CTRL_W,
   parameter int DATA_W = MEMWB_DATA_W,
   parameter int TAG_W  = MEMWB_TAG_W
);

   logic              VALID;
   logic              READY;
   logic [CTRL_W-1:0] CTRL;
   logic [DATA_W-1:0] DATA;
   logic [TAG_W-1:0]  TAG;

   modport master (output VALID, CTRL, DATA, TAG, input  READY);
   modport slave  (input  VALID, CTRL, DATA, TAG, output READY);

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One payload slot: valid bit plus ctrl/data/tag. Clearing drops valid and
// zeroes ctrl only, so an empty slot always presents a bubble.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = MEMWB_CTRL_W,
   parameter int DATA_W = MEMWB_DATA_W,
   parameter int TAG_W  = MEMWB_TAG_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   input  logic [TAG_W-1:0]  d_tag,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data,
   output logic [TAG_W-1:0]  tag
);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
         tag   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
         data  <= d_data;
         tag   <= d_tag;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry
// skid buffer, STALL freeze, FLUSH bubble insertion and occupancy count.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W = MEMWB_CTRL_W,
   parameter int DATA_W = MEMWB_DATA_W,
   parameter int TAG_W  = MEMWB_TAG_W,
   parameter int SKID   = 1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   STALL,
   input  logic                   FLUSH,
   pipe_stage_skid_if.slave       in_bus,
   pipe_stage_skid_if.master      out_bus,
   output logic [1:0]             COUNT
);

   cnt_st_e st, st_nxt;

   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
   logic [DATA_W-1:0] m_data, s_data, m_d_data;
   logic [TAG_W-1:0]  m_tag, s_tag, m_d_tag;
   logic              m_load, m_clr, m_from_s, s_load, s_clr;
   logic              in_ready, out_valid, acc, rel;

   assign out_valid = m_valid & ~STALL;
   assign acc       = in_bus.VALID & in_ready;
   assign rel       = out_valid & out_bus.READY;

   // The skid build keeps IN_READY off the OUT_READY path entirely.
   if (SKID != 0) begin : g_rdy_skid
      assign in_ready = ~STALL & ~s_valid;
   end else begin : g_rdy_flow
      assign in_ready = ~STALL & (~m_valid | out_bus.READY);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) st <= ST_EMPTY;
      else        st <= st_nxt;
   end

   // In the single-slot build an accept from ONE always coincides with a
   // release, so the ONE->TWO arc is never taken there.
   always_comb begin
      st_nxt   = st;
      m_load   = 1'b0;
      m_clr    = 1'b0;
      m_from_s = 1'b0;
      s_load   = 1'b0;
      s_clr    = 1'b0;
      if (FLUSH) begin
         st_nxt = ST_EMPTY;
         m_clr  = 1'b1;
         s_clr  = 1'b1;
      end else if (!STALL) begin
         case (st)
            ST_EMPTY: if (acc) begin
               m_load = 1'b1;
               st_nxt = ST_ONE;
            end
            ST_ONE: begin
               if (acc && rel) begin
                  m_load = 1'b1;
               end else if (acc) begin
                  s_load = 1'b1;
                  st_nxt = ST_TWO;
               end else if (rel) begin
                  m_clr  = 1'b1;
                  st_nxt = ST_EMPTY;
               end
            end
            ST_TWO: if (rel) begin
               m_load   = 1'b1;
               m_from_s = 1'b1;
               s_clr    = 1'b1;
               st_nxt   = ST_ONE;
            end
            default: st_nxt = ST_EMPTY;
         endcase
      end
   end

   assign m_d_ctrl = m_from_s ? s_ctrl : in_bus.CTRL;
   assign m_d_data = m_from_s ? s_data : in_bus.DATA;
   assign m_d_tag  = m_from_s ? s_tag  : in_bus.TAG;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_m (
      .CLK    (CLK),
      .RESET  (RESET),
      .load   (m_load),
      .clear  (m_clr),
      .d_ctrl (m_d_ctrl),
      .d_data (m_d_data),
      .d_tag  (m_d_tag),
      .valid  (m_valid),
      .ctrl   (m_ctrl),
      .data   (m_data),
      .tag    (m_tag)
   );

   if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_s (
         .CLK    (CLK),
         .RESET  (RESET),
         .load   (s_load),
         .clear  (s_clr),
         .d_ctrl (in_bus.CTRL),
         .d_data (in_bus.DATA),
         .d_tag  (in_bus.TAG),
         .valid  (s_valid),
         .ctrl   (s_ctrl),
         .data   (s_data),
         .tag    (s_tag)
      );
   end else begin : g_noskid
      logic unused_s;
      assign s_valid  = 1'b0;
      assign s_ctrl   = '0;
      assign s_data   = '0;
      assign s_tag    = '0;
      assign unused_s = ^{s_load, s_clr, s_valid};
   end

   assign in_bus.READY  = in_ready;
   assign out_bus.VALID = out_valid;
   assign out_bus.CTRL  = m_ctrl;
   assign out_bus.DATA  = m_data;
   assign out_bus.TAG   = m_tag;
   assign COUNT         = st;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives a skid build and a single-slot build with identical stimulus and
// checks both against a queue model, plus hand-computed directed checks.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int CW = MEMWB_CTRL_W;
   localparam int DW = MEMWB_DATA_W;
   localparam int TW = MEMWB_TAG_W;

   logic          CLK = 1'b0;
   logic          RESET, STALL, FLUSH, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic [TW-1:0] in_tag;
   logic [1:0]    cnt1, cnt0;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW)) i1 ();
   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW)) o1 ();
   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW)) i0 ();
   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW)) o0 ();

   assign i1.VALID = in_valid;
   assign i1.CTRL  = in_ctrl;
   assign i1.DATA  = in_data;
   assign i1.TAG   = in_tag;
   assign o1.READY = out_ready;
   assign i0.VALID = in_valid;
   assign i0.CTRL  = in_ctrl;
   assign i0.DATA  = in_data;
   assign i0.TAG   = in_tag;
   assign o0.READY = out_ready;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW), .SKID(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
      .in_bus(i1), .out_bus(o1), .COUNT(cnt1));

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW), .SKID(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
      .in_bus(i0), .out_bus(o0), .COUNT(cnt0));

   // ---------------- reference model: a FIFO of capacity 2 or 1 ----------
   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic [TW-1:0] t;
   } ent_t;
   typedef ent_t eq_t[$];

   eq_t           q1, q0;
   logic [DW-1:0] hd1_d, hd0_d;
   logic [TW-1:0] hd1_t, hd0_t;
   bit            live = 0;

   function automatic eq_t nxt_q(input eq_t q, input bit skid);
      eq_t r;
      bit  rdy, acc, rel;
      r = q;
      if (!RESET || FLUSH) begin
         r.delete();
      end else if (!STALL) begin
         rdy = skid ? (r.size() < 2) : (r.size() == 0 || out_ready);
         acc = in_valid && rdy;
         rel = (r.size() > 0) && out_ready;
         if (rel) void'(r.pop_front());
         if (acc) r.push_back({in_ctrl, in_data, in_tag});
      end
      return r;
   endfunction

   always @(posedge CLK) begin
      q1 = nxt_q(q1, 1'b1);
      q0 = nxt_q(q0, 1'b0);
      // Data/tag outputs show the most recent head; only reset clears them.
      if (!RESET) begin
         hd1_d = '0; hd1_t = '0; hd0_d = '0; hd0_t = '0;
         live  = 1;
      end else begin
         if (q1.size() > 0) begin hd1_d = q1[0].d; hd1_t = q1[0].t; end
         if (q0.size() > 0) begin hd0_d = q0[0].d; hd0_t = q0[0].t; end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input string nm, input bit skid, input eq_t q,
                      input logic [DW-1:0] hd_d, input logic [TW-1:0] hd_t,
                      input logic ov, input logic ir, input logic [1:0] cn,
                      input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [TW-1:0] t);
      logic          e_ov, e_ir;
      logic [CW-1:0] e_c;
      e_ov = (q.size() > 0) && !STALL;
      e_ir = !STALL && (skid ? (q.size() < 2) : (q.size() == 0 || out_ready));
      e_c  = '0;
      if (q.size() > 0) e_c = q[0].c;
      chk({nm, " out_valid"}, 64'(ov), 64'(e_ov));
      chk({nm, " in_ready"},  64'(ir), 64'(e_ir));
      chk({nm, " count"},     64'(cn), 64'(q.size()));
      chk({nm, " out_ctrl"},  64'(c),  64'(e_c));
      chk({nm, " out_data"},  64'(d),  64'(hd_d));
      chk({nm, " out_tag"},   64'(t),  64'(hd_t));
   endtask

   always @(negedge CLK) begin
      if (live) begin
         cmp("m1", 1'b1, q1, hd1_d, hd1_t, o1.VALID, i1.READY, cnt1, o1.CTRL, o1.DATA, o1.TAG);
         cmp("m0", 1'b0, q0, hd0_d, hd0_t, o0.VALID, i0.READY, cnt0, o0.CTRL, o0.DATA, o0.TAG);
      end
   end

   // ---------------- stimulus: inputs change only just after posedge -----
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
      in_valid = 1'b1; in_tag = 5'h1F; in_ctrl = 2'b11; in_data = 64'hDEAD_BEEF_0123_4567;
      out_ready = 1'b0;
      step(); step();
      RESET = 1'b1; in_valid = 1'b0;
      @(negedge CLK);
      chk("rst count", 64'(cnt1), 64'd0);
      chk("rst out_valid", 64'(o1.VALID), 64'd0);
      chk("rst out_ctrl", 64'(o1.CTRL), 64'd0);
      chk("rst out_data", o1.DATA, 64'd0);
      chk("rst out_tag", 64'(o1.TAG), 64'd0);
      chk("rst in_ready", 64'(i1.READY), 64'd1);
      step();

      // streaming, one per cycle
      out_ready = 1'b1; in_ctrl = 2'b01; in_valid = 1'b1; in_tag = 5'd1;
      step();
      for (int i = 2; i <= 9; i++) begin
         if (i <= 8) in_tag = TW'(i);
         else in_valid = 1'b0;
         @(negedge CLK);
         chk("stream tag", 64'(o1.TAG), 64'(i - 1));
         chk("stream count", 64'(cnt1), 64'd1);
         step();
      end
      @(negedge CLK);
      chk("stream drained", 64'(cnt1), 64'd0);

      // backpressure into the skid slot
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd3;
      step();
      in_tag = 5'd4;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge CLK);
      chk("bp count", 64'(cnt1), 64'd2);
      chk("bp in_ready", 64'(i1.READY), 64'd0);
      chk("bp tag held", 64'(o1.TAG), 64'd3);
      step();
      @(negedge CLK);
      chk("bp tag second", 64'(o1.TAG), 64'd4);
      chk("bp ready back", 64'(i1.READY), 64'd1);
      step();
      @(negedge CLK);
      chk("bp drained", 64'(cnt1), 64'd0);

      // stall freezes a held entry
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd7;
      step();
      in_valid = 1'b0; STALL = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("stall out_valid", 64'(o1.VALID), 64'd0);
         chk("stall in_ready", 64'(i1.READY), 64'd0);
         chk("stall count", 64'(cnt1), 64'd1);
         chk("stall tag", 64'(o1.TAG), 64'd7);
         step();
      end
      STALL = 1'b0;
      @(negedge CLK);
      chk("unstall valid", 64'(o1.VALID), 64'd1);
      chk("unstall tag", 64'(o1.TAG), 64'd7);
      step();
      @(negedge CLK);
      chk("unstall once", 64'(cnt1), 64'd0);

      // flush with a simultaneous accept
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_tag = 5'd3;
      step();
      in_tag = 5'd4;
      step();
      FLUSH = 1'b1; in_tag = 5'd9;
      @(negedge CLK);
      chk("pre-flush count", 64'(cnt1), 64'd2);
      chk("pre-flush ctrl", 64'(o1.CTRL), 64'd3);
      step();
      FLUSH = 1'b0; in_valid = 1'b0;
      @(negedge CLK);
      chk("flush count", 64'(cnt1), 64'd0);
      chk("flush ctrl", 64'(o1.CTRL), 64'd0);
      chk("flush valid", 64'(o1.VALID), 64'd0);
      chk("flush tag hold", 64'(o1.TAG), 64'd3);
      step();

      // flush wins over stall
      in_valid = 1'b1; in_tag = 5'd5;
      step();
      in_valid = 1'b0; STALL = 1'b1; FLUSH = 1'b1;
      step();
      STALL = 1'b0; FLUSH = 1'b0;
      @(negedge CLK);
      chk("flush+stall count", 64'(cnt1), 64'd0);
      chk("flush+stall ctrl", 64'(o1.CTRL), 64'd0);
      step();

      // single-slot build: combinational ready and same-cycle replace
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd6;
      step();
      in_valid = 1'b0;
      @(negedge CLK);
      chk("s0 count", 64'(cnt0), 64'd1);
      chk("s0 ready blocked", 64'(i0.READY), 64'd0);
      step();
      out_ready = 1'b1; in_valid = 1'b1; in_tag = 5'd10;
      @(negedge CLK);
      chk("s0 ready flow", 64'(i0.READY), 64'd1);
      step();
      in_valid = 1'b0;
      @(negedge CLK);
      chk("s0 replace count", 64'(cnt0), 64'd1);
      chk("s0 replace tag", 64'(o0.TAG), 64'd10);
      step();
      @(negedge CLK);
      chk("s0 drained", 64'(cnt0), 64'd0);
      step();

      // randomized traffic
      repeat (3000) begin
         RESET     = ($urandom_range(99) != 0);
         STALL     = ($urandom_range(9) == 0);
         FLUSH     = ($urandom_range(31) == 0);
         in_valid  = $urandom_range(1) == 1;
         out_ready = ($urandom_range(9) < 7);
         in_ctrl   = CW'($urandom);
         in_data   = {$urandom, $urandom};
         in_tag    = TW'($urandom);
         step();
      end
      RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
      @(negedge CLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
